// File: rtl/vis_bar_writer.sv
// vis_bar_writer: scales row updates into a shadow array and sweeps it to the visualizer RAM in vblank; VIS_BAR_DECAY_EN enables per-frame decay
module vis_bar_writer #(
  parameter int SCREEN_HEIGHT = 42,
  parameter int SCREEN_WIDTH  = 76,
  parameter int ACTIVE_V      = 720,
  parameter int SHIFT         = 0,
  parameter int DECAY_STEP    = 16
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  input  logic                             upd_valid,
  output logic                             upd_ready,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] upd_row,
  input  logic [31:0]                      upd_value,
  output logic                             tg_write_en,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] tg_addr,
  output logic [31:0]                      tg_input,
  output logic                             upd_drop,
  output logic                             frame_done
);
  localparam int AW = $clog2(SCREEN_HEIGHT);
  localparam int RW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [31:0] MAX_PX = 32'(16 * SCREEN_WIDTH);
  localparam logic [31:0] DSTEP = 32'(DECAY_STEP);
  localparam logic [9:0] LINE = 10'(ACTIVE_V);
  localparam logic [RW-1:0] ROWS = RW'(SCREEN_HEIGHT);
`ifdef VIS_BAR_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SWEEP, ARMED} state_t;
  state_t state;
  logic [RW-1:0] r;
  logic [31:0] shadow [SCREEN_HEIGHT];
  logic [31:0] shifted, len, cur, decayed;
  logic start, accept, in_range, emit;
  logic [AW-1:0] emit_row;
  assign upd_ready = !rst_in && state != SWEEP;
  // row 0 is emitted on the start edge itself so the write lands one cycle after start
  always_comb begin
    shifted = upd_value >> SHIFT;
    len = shifted > MAX_PX ? MAX_PX : shifted;
    start = vcount_in == LINE && hcount_in == '0;
    in_range = {1'b0, upd_row} < (AW+1)'(SCREEN_HEIGHT);
    accept = upd_valid && upd_ready;
    emit = state == IDLE ? start : (state == SWEEP && r != ROWS);
    emit_row = state == SWEEP ? r[AW-1:0] : '0;
    cur = shadow[emit_row];
    decayed = cur > DSTEP ? cur - DSTEP : '0;
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      r <= '0;
      tg_write_en <= 1'b0;
      tg_addr <= '0;
      tg_input <= '0;
      upd_drop <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      upd_drop <= accept && !in_range;
      tg_write_en <= emit;
      tg_addr <= emit ? emit_row : '0;
      tg_input <= emit ? cur : '0;
      frame_done <= state == SWEEP && r == ROWS;
      r <= emit ? RW'(emit_row) + RW'(1) : '0;
      state <= state == IDLE ? (start ? SWEEP : IDLE) :
               state == SWEEP ? (r == ROWS ? ARMED : SWEEP) :
               (vcount_in < LINE ? IDLE : ARMED);
    end
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < SCREEN_HEIGHT; i++) shadow[i] <= '0;
    end else begin
      if (emit && DECAY) shadow[emit_row] <= decayed;
      if (accept && in_range) shadow[upd_row] <= len;
    end
  end
endmodule

// File: tb/tb_vis_bar_writer.sv
// tb_vis_bar_writer: scoreboard bench for vis_bar_writer; follows VIS_BAR_DECAY_EN when defined
module tb_vis_bar_writer;
  logic pixel_clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0] vcount_in = '0;
  logic upd_valid = 1'b0;
  logic [5:0] upd_row = '0;
  logic [31:0] upd_value = '0;
  logic upd_ready, tg_write_en, upd_drop, frame_done;
  logic [5:0] tg_addr;
  logic [31:0] tg_input;
  logic rdy2, we2, drop2, done2;
  logic [5:0] addr2;
  logic [31:0] in2;
  int checks = 0, failures = 0, writes = 0;
  logic [37:0] sb [$];
  logic [31:0] exp_sh [42];
  logic [31:0] cap2 [64];

  always #5 pixel_clk_in = ~pixel_clk_in;

  vis_bar_writer dut (
    .pixel_clk_in(pixel_clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_row(upd_row), .upd_value(upd_value),
    .tg_write_en(tg_write_en), .tg_addr(tg_addr), .tg_input(tg_input),
    .upd_drop(upd_drop), .frame_done(frame_done)
  );

  vis_bar_writer #(.SHIFT(2)) dut_shift (
    .pixel_clk_in(pixel_clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .upd_valid(upd_valid), .upd_ready(rdy2), .upd_row(upd_row), .upd_value(upd_value),
    .tg_write_en(we2), .tg_addr(addr2), .tg_input(in2),
    .upd_drop(drop2), .frame_done(done2)
  );

  function automatic logic [31:0] scale(input logic [31:0] v, input int sh);
    logic [31:0] s;
    s = v >> sh;
    return s > 32'd1216 ? 32'd1216 : s;
  endfunction

  always @(negedge pixel_clk_in) begin
    logic [37:0] e;
    if (tg_write_en === 1'b1) begin
      checks++;
      writes++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sweep_extra got addr=%0d data=%0d expected no write", tg_addr, tg_input);
      end else begin
        e = sb.pop_front();
        if ({tg_addr, tg_input} !== e) begin
          failures++;
          $display("FAIL sweep_write got addr=%0d data=%0d expected addr=%0d data=%0d",
                   tg_addr, tg_input, e[37:32], e[31:0]);
        end
      end
    end
    if (we2 === 1'b1) cap2[addr2] = in2;
  end

  task automatic push_frame();
    for (int i = 0; i < 42; i++) begin
      sb.push_back({6'(i), exp_sh[i]});
`ifdef VIS_BAR_DECAY_EN
      exp_sh[i] = exp_sh[i] > 32'd16 ? exp_sh[i] - 32'd16 : 32'd0;
`endif
    end
  endtask

  task automatic run_frame(output int fd, output int rl);
    fd = 0;
    rl = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge pixel_clk_in);
      fd += int'(frame_done);
      rl += int'(!upd_ready);
      if (i < 3) begin
        vcount_in = 10'd100;
        hcount_in = 11'(i + 5);
      end else if (i == 3) begin
        vcount_in = 10'd720;
        hcount_in = '0;
        push_frame();
      end else if (i < 64) begin
        vcount_in = 10'd720;
        hcount_in = (i == 30 || i == 55) ? 11'd0 : 11'(i);
      end else begin
        vcount_in = 10'd0;
        hcount_in = 11'(i);
      end
    end
  endtask

  task automatic send(input logic [5:0] row, input logic [31:0] val, output int waited, output logic drop);
    @(negedge pixel_clk_in);
    upd_valid = 1'b1;
    upd_row = row;
    upd_value = val;
    waited = 0;
    while (!upd_ready && waited < 200) begin
      @(negedge pixel_clk_in);
      waited++;
    end
    checks++;
    if (waited >= 200) begin
      failures++;
      $display("FAIL send_accept got no ready after %0d cycles expected acceptance", waited);
    end
    @(negedge pixel_clk_in);
    drop = upd_drop;
    upd_valid = 1'b0;
    if (row < 6'd42) exp_sh[row] = scale(val, 0);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge pixel_clk_in);
    checks++;
    if ({tg_write_en, tg_addr, tg_input, upd_drop, frame_done, upd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b addr=%0d data=%0d drop=%b done=%b ready=%b expected all 0",
               tg_write_en, tg_addr, tg_input, upd_drop, frame_done, upd_ready);
    end
    rst_in = 1'b0;
    for (int i = 0; i < 42; i++) exp_sh[i] = '0;
    sb.delete();
    @(negedge pixel_clk_in);
    checks++;
    if (upd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b expected 1", upd_ready);
    end
  endtask

  task automatic test_empty_frame();
    int fd, rl, w0;
    w0 = writes;
    run_frame(fd, rl);
    checks++;
    if (fd != 1) begin failures++; $display("FAIL empty_done got %0d pulses expected 1", fd); end
    checks++;
    if (rl != 42) begin failures++; $display("FAIL empty_ready_low got %0d expected 42", rl); end
    checks++;
    if (writes - w0 != 42) begin failures++; $display("FAIL empty_writes got %0d expected 42", writes - w0); end
  endtask

  task automatic test_updates();
    int fd, rl, w;
    logic d;
    send(6'd5, 32'd300, w, d);
    send(6'd41, 32'd5000, w, d);
    run_frame(fd, rl);
    checks++;
    if (fd != 1) begin failures++; $display("FAIL updates_done got %0d expected 1", fd); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL updates_pending got %0d expected 0", sb.size()); end
  endtask

  task automatic test_shift();
    int fd, rl, w;
    logic d;
    for (int i = 0; i < 64; i++) cap2[i] = 32'hDEAD_BEEF;
    send(6'd0, 32'hFFFF_FFFF, w, d);
    send(6'd1, 32'd400, w, d);
    run_frame(fd, rl);
    checks++;
    if (cap2[0] !== 32'd1216) begin failures++; $display("FAIL shift_row0 got %0d expected 1216", cap2[0]); end
    checks++;
    if (cap2[1] !== 32'd100) begin failures++; $display("FAIL shift_row1 got %0d expected 100", cap2[1]); end
  endtask

  task automatic test_back_to_back();
    int fd, rl;
    @(negedge pixel_clk_in);
    upd_valid = 1'b1;
    upd_row = 6'd9;
    upd_value = 32'd11;
    @(negedge pixel_clk_in);
    upd_value = 32'd22;
    @(negedge pixel_clk_in);
    upd_valid = 1'b0;
    exp_sh[9] = 32'd22;
    run_frame(fd, rl);
    checks++;
    if (fd != 1) begin failures++; $display("FAIL b2b_done got %0d expected 1", fd); end
  endtask

  task automatic test_hold_and_drop();
    int fd, rl, w, n;
    logic d;
    fork
      run_frame(fd, rl);
      begin
        n = 0;
        while (tg_write_en !== 1'b1 && n < 100) begin
          @(negedge pixel_clk_in);
          n++;
        end
        send(6'd7, 32'd777, w, d);
      end
    join
    checks++;
    if (rl != 42) begin failures++; $display("FAIL hold_ready_low got %0d expected 42", rl); end
    checks++;
    if (w == 0) begin failures++; $display("FAIL hold_wait got %0d cycles expected >0", w); end
    send(6'd42, 32'd999, w, d);
    checks++;
    if (d !== 1'b1) begin failures++; $display("FAIL drop_pulse got %b expected 1", d); end
    @(negedge pixel_clk_in);
    checks++;
    if (upd_drop !== 1'b0) begin failures++; $display("FAIL drop_width got %b expected 0", upd_drop); end
    send(6'd2, 32'd50, w, d);
    checks++;
    if (d !== 1'b0) begin failures++; $display("FAIL drop_valid_row got %b expected 0", d); end
    run_frame(fd, rl);
    checks++;
    if (fd != 1) begin failures++; $display("FAIL hold_next_done got %0d expected 1", fd); end
  endtask

  task automatic test_reset_mid();
    int fd, rl, n;
    fd = 0;
    n = 0;
    @(negedge pixel_clk_in);
    vcount_in = 10'd100;
    hcount_in = 11'd3;
    @(negedge pixel_clk_in);
    vcount_in = 10'd720;
    hcount_in = '0;
    push_frame();
    @(negedge pixel_clk_in);
    hcount_in = 11'd1;
    while (!(tg_write_en === 1'b1 && tg_addr == 6'd20) && n < 100) begin
      @(negedge pixel_clk_in);
      fd += int'(frame_done);
      n++;
    end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL midrst_reach got no row 20 expected row 20 write"); end
    rst_in = 1'b1;
    @(negedge pixel_clk_in);
    checks++;
    if (tg_write_en !== 1'b0) begin failures++; $display("FAIL midrst_abort got we=%b expected 0", tg_write_en); end
    rst_in = 1'b0;
    sb.delete();
    for (int i = 0; i < 42; i++) exp_sh[i] = '0;
    repeat (60) begin
      @(negedge pixel_clk_in);
      fd += int'(frame_done);
    end
    checks++;
    if (fd != 0) begin failures++; $display("FAIL midrst_done got %0d expected 0", fd); end
    run_frame(fd, rl);
    checks++;
    if (fd != 1) begin failures++; $display("FAIL midrst_next_done got %0d expected 1", fd); end
  endtask

  task automatic test_persist();
    int fd, rl, w;
    logic d;
    send(6'd3, 32'd40, w, d);
    repeat (5) run_frame(fd, rl);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL persist_pending got %0d expected 0", sb.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_frame();
    test_updates();
    test_shift();
    test_back_to_back();
    test_hold_and_drop();
    test_reset_mid();
    test_persist();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
